// File: rtl/imem_responder_if.sv
// Fetch and loader bus for the instruction-memory responder.
// The misalign signal exists only when IMEM_ALIGN_CHECK_EN is defined.
interface imem_responder_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024
);
   localparam int CNT_W = $clog2(DEPTH_WORDS) + 1;

   logic                  imem_rd_en;
   logic [ADDR_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] inst_imem;
   logic                  fetch_hold;
   logic                  ld_start;
   logic                  ld_valid;
   logic [7:0]            ld_byte;
   logic                  ld_ready;
   logic                  ld_done;
   logic [CNT_W-1:0]      ld_words;
`ifdef IMEM_ALIGN_CHECK_EN
   logic                  misalign;
`endif

   modport master (
      output imem_rd_en, pc, ld_start, ld_valid, ld_byte,
`ifdef IMEM_ALIGN_CHECK_EN
      input  misalign,
`endif
      input  inst_imem, fetch_hold, ld_ready, ld_done, ld_words
   );

   modport slave (
      input  imem_rd_en, pc, ld_start, ld_valid, ld_byte,
`ifdef IMEM_ALIGN_CHECK_EN
      output misalign,
`endif
      output inst_imem, fetch_hold, ld_ready, ld_done, ld_words
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one-cycle registered fetch from a word array,
// plus a byte-stream program loader (RUN / LOAD / FLUSH) that fills the array
// at run time while holding the fetch stage off.
// Optional feature macro: IMEM_ALIGN_CHECK_EN (flags fetches with pc[1:0] != 0).
module imem_responder #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH_WORDS = 1024,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD    = DATA_WIDTH'(32'h00000013)
) (
   input  logic             clk,
   input  logic             rst,
   imem_responder_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = IDX_W + 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [1:0]            byte_cnt;
   logic [CNT_W-1:0]      word_ptr;
   logic [CNT_W-1:0]      ld_words_q;
   logic [23:0]           byte_buf;
   logic                  ld_done_q;
   logic [DATA_WIDTH-1:0] inst_p1;
   logic                  mis_p1;

   logic                  load_go;
   logic                  byte_acc;
   logic                  word_wr;
   logic                  part_wr;
   logic                  hold_c;
   logic                  ready_c;
   logic                  ptr_room;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_in_range;

   assign ptr_room    = (word_ptr < CNT_W'(DEPTH_WORDS));
   assign wr_idx      = word_ptr[IDX_W-1:0];
   assign rd_idx      = bus.pc[IDX_W+1:2];
   assign rd_in_range = ((bus.pc >> 2) < ADDR_WIDTH'(DEPTH_WORDS));
   // Writes are suppressed under reset so a partially assembled word is never committed.
   assign mem_we      = (word_wr || part_wr) && !rst;
   assign mem_wdata   = word_wr ? DATA_WIDTH'({bus.ld_byte, byte_buf})
                                : DATA_WIDTH'({8'h00, byte_buf});

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // Next-state decode and per-state loader strobes.
   always_comb begin
      state_nxt = state;
      load_go   = 1'b0;
      byte_acc  = 1'b0;
      word_wr   = 1'b0;
      part_wr   = 1'b0;
      hold_c    = 1'b0;
      ready_c   = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (bus.ld_start) begin
               load_go   = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            hold_c   = 1'b1;
            ready_c  = ptr_room;
            byte_acc = bus.ld_valid && ptr_room;
            word_wr  = byte_acc && (byte_cnt == 2'd3);
            if (bus.ld_start) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            hold_c    = 1'b1;
            part_wr   = (byte_cnt != 2'd0) && ptr_room;
            state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Loader counters: byte position within word, write pointer, words-written count.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt   <= 2'd0;
         word_ptr   <= '0;
         ld_words_q <= '0;
      end else if (load_go) begin
         byte_cnt   <= 2'd0;
         word_ptr   <= '0;
         ld_words_q <= '0;
      end else if (byte_acc) begin
         if (byte_cnt == 2'd3) begin
            byte_cnt   <= 2'd0;
            word_ptr   <= word_ptr + CNT_W'(1);
            ld_words_q <= ld_words_q + CNT_W'(1);
         end else begin
            byte_cnt <= byte_cnt + 2'd1;
         end
      end else if (state == ST_FLUSH) begin
         byte_cnt <= 2'd0;
         if (part_wr) ld_words_q <= ld_words_q + CNT_W'(1);
      end
   end

   // Assembly buffer for the low three bytes; cleared so a partial word flushes with zero upper bytes.
   always_ff @(posedge clk) begin
      if (load_go || word_wr) begin
         byte_buf <= '0;
      end else if (byte_acc) begin
         case (byte_cnt)
            2'd0:    byte_buf[7:0]   <= bus.ld_byte;
            2'd1:    byte_buf[15:8]  <= bus.ld_byte;
            2'd2:    byte_buf[23:16] <= bus.ld_byte;
            default: byte_buf        <= byte_buf;
         endcase
      end
   end

   // Word array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_idx] <= mem_wdata;
   end

   // Fetch stage: registered instruction word, NOP while the loader owns the array.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_p1 <= NOP_WORD;
         mis_p1  <= 1'b0;
      end else if (state != ST_RUN || bus.ld_start) begin
         inst_p1 <= NOP_WORD;
         mis_p1  <= 1'b0;
      end else if (bus.imem_rd_en) begin
`ifdef IMEM_ALIGN_CHECK_EN
         if (bus.pc[1:0] != 2'b00) begin
            inst_p1 <= NOP_WORD;
            mis_p1  <= 1'b1;
         end else begin
            inst_p1 <= rd_in_range ? mem[rd_idx] : NOP_WORD;
            mis_p1  <= 1'b0;
         end
`else
         inst_p1 <= rd_in_range ? mem[rd_idx] : NOP_WORD;
         mis_p1  <= 1'b0;
`endif
      end
   end

   // Load-complete pulse, raised for the cycle following FLUSH.
   always_ff @(posedge clk) begin
      if (rst) ld_done_q <= 1'b0;
      else     ld_done_q <= (state == ST_FLUSH);
   end

   assign bus.inst_imem  = inst_p1;
   assign bus.fetch_hold = hold_c;
   assign bus.ld_ready   = ready_c;
   assign bus.ld_done    = ld_done_q;
   assign bus.ld_words   = ld_words_q;
`ifdef IMEM_ALIGN_CHECK_EN
   assign bus.misalign   = mis_p1;
`else
   logic unused_mis;
   assign unused_mis = mis_p1;
`endif
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: randomized loads and fetches against a
// byte-level program model; a negedge monitor compares queued expectations.
module tb_imem_responder;
   localparam int D = 16;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum int {K_INST, K_READY, K_HOLD, K_DONE, K_WORDS, K_MIS} kind_e;
   typedef struct {
      int          cyc;
      kind_e       kind;
      logic [31:0] exp;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];
   exp_t keep[$];

   logic [31:0] model_mem [D];
   logic [31:0] last_inst;

   imem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(D)) bus ();

   imem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kind_name(kind_e k);
      case (k)
         K_INST:  return "inst_imem";
         K_READY: return "ld_ready";
         K_HOLD:  return "fetch_hold";
         K_DONE:  return "ld_done";
         K_WORDS: return "ld_words";
         default: return "misalign";
      endcase
   endfunction

   function automatic logic [31:0] actual(kind_e k);
      case (k)
         K_INST:  return bus.inst_imem;
         K_READY: return 32'(bus.ld_ready);
         K_HOLD:  return 32'(bus.fetch_hold);
         K_DONE:  return 32'(bus.ld_done);
         K_WORDS: return 32'(bus.ld_words);
`ifdef IMEM_ALIGN_CHECK_EN
         K_MIS:   return 32'(bus.misalign);
`endif
         default: return 32'hdeadbeef;
      endcase
   endfunction

   // Monitor: compare every expectation due this cycle; anything overdue is an error.
   always @(negedge clk) begin
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].cyc == cyc) begin
            n_cmp++;
            if (actual(sb[i].kind) !== sb[i].exp) begin
               n_bad++;
               $display("FAIL %s cyc=%0d got=%h want=%h", kind_name(sb[i].kind), cyc,
                        actual(sb[i].kind), sb[i].exp);
            end
         end else if (sb[i].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stale_%s cyc=%0d due=%0d", kind_name(sb[i].kind), cyc, sb[i].cyc);
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int c, input kind_e k, input logic [31:0] v);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic idle_inputs();
      bus.imem_rd_en = 1'b0;
      bus.ld_start   = 1'b0;
      bus.ld_valid   = 1'b0;
      bus.ld_byte    = 8'($urandom);
      bus.pc         = $urandom;
   endtask

   task automatic fetch(input logic [31:0] pc);
      logic [31:0] e;
      int unsigned idx;
      idle_inputs();
      bus.imem_rd_en = 1'b1;
      bus.pc         = pc;
      idx = pc >> 2;
      e   = (idx < D) ? model_mem[idx] : NOP;
`ifdef IMEM_ALIGN_CHECK_EN
      if (pc[1:0] != 2'b00) e = NOP;
      expect_at(cyc + 1, K_MIS, 32'(pc[1:0] != 2'b00));
`endif
      expect_at(cyc + 1, K_INST, e);
      last_inst = e;
      step();
      idle_inputs();
   endtask

   task automatic hold_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         idle_inputs();
         expect_at(cyc, K_INST, last_inst);
         step();
      end
   endtask

   // Model: the first 4*D bytes presented are accepted; words are packed little-endian.
   task automatic load(input logic [7:0] bytes[$], input bit merge_end);
      int acc;
      int n;
      int words;
      logic [31:0] w;
      idle_inputs();
      bus.ld_start = 1'b1;
      step();
      idle_inputs();
      expect_at(cyc, K_HOLD, 32'd1);
      expect_at(cyc, K_INST, NOP);
      acc = 0;
      n   = bytes.size();
      for (int i = 0; i < n; i++) begin
         idle_inputs();
         while ($urandom_range(3) == 0) begin
            step();
            idle_inputs();
         end
         bus.ld_valid = 1'b1;
         bus.ld_byte  = bytes[i];
         if (merge_end && i == n - 1) bus.ld_start = 1'b1;
         expect_at(cyc, K_READY, 32'(acc < 4 * D));
         if (acc < 4 * D) acc++;
         step();
      end
      if (!(merge_end && n > 0)) begin
         idle_inputs();
         bus.ld_start = 1'b1;
         step();
      end
      idle_inputs();
      words = (acc + 3) / 4;
      expect_at(cyc, K_HOLD, 32'd1);
      expect_at(cyc, K_READY, 32'd0);
      expect_at(cyc, K_DONE, 32'd0);
      expect_at(cyc + 1, K_DONE, 32'd1);
      expect_at(cyc + 1, K_HOLD, 32'd0);
      expect_at(cyc + 1, K_WORDS, 32'(words));
      expect_at(cyc + 1, K_INST, NOP);
      expect_at(cyc + 2, K_DONE, 32'd0);
      for (int wi = 0; wi < words; wi++) begin
         w = 32'd0;
         for (int b = 0; b < 4; b++)
            if (4 * wi + b < acc) w = w | (32'(bytes[4 * wi + b]) << (8 * b));
         model_mem[wi] = w;
      end
      last_inst = NOP;
      step();
   endtask

   task automatic random_fetches(input int n);
      logic [31:0] pc;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(7) == 0) pc = $urandom | 32'h0001_0000;
         else if ($urandom_range(7) == 0) pc = 32'(4 * D + 4 * $urandom_range(3));
         else pc = 32'(4 * $urandom_range(D - 1)) | 32'($urandom_range(3) == 0 ? $urandom_range(3) : 0);
         fetch(pc);
         if ($urandom_range(4) == 0) hold_cycles($urandom_range(1, 2));
      end
   endtask

   initial begin
      logic [7:0] q[$];
      cyc   = 0;
      n_cmp = 0;
      n_bad = 0;
      last_inst = NOP;
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      step();
      rst = 1'b0;
      expect_at(cyc, K_INST, NOP);
      expect_at(cyc, K_HOLD, 32'd0);
      expect_at(cyc, K_READY, 32'd0);
      expect_at(cyc, K_DONE, 32'd0);
      expect_at(cyc, K_WORDS, 32'd0);
`ifdef IMEM_ALIGN_CHECK_EN
      expect_at(cyc, K_MIS, 32'd0);
`endif
      step();

      // Two-instruction program.
      q = {8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
      load(q, 1'b0);
      fetch(32'h0);
      fetch(32'h4);

      // Partial trailing word, with the end strobe on the last byte.
      q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      load(q, 1'b1);
      fetch(32'h4);
      hold_cycles(3);
      fetch(32'h0);
      fetch(32'(4 * D));
      hold_cycles(3);

      // Overfill: three extra bytes are dropped, flush writes nothing.
      q = {};
      for (int i = 0; i < 4 * D + 3; i++) q.push_back(8'($urandom));
      load(q, 1'b0);
      random_fetches(30);

`ifdef IMEM_ALIGN_CHECK_EN
      fetch(32'h6);
      hold_cycles(2);
      fetch(32'h4);
`endif

      // Reset in the middle of a load, after five bytes.
      idle_inputs();
      bus.ld_start = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         idle_inputs();
         bus.ld_valid = 1'b1;
         bus.ld_byte  = 8'(8'h40 + i);
         step();
      end
      model_mem[0] = 32'h43424140;
      idle_inputs();
      rst = 1'b1;
      expect_at(cyc + 1, K_HOLD, 32'd0);
      expect_at(cyc + 1, K_DONE, 32'd0);
      expect_at(cyc + 1, K_READY, 32'd0);
      expect_at(cyc + 1, K_WORDS, 32'd0);
      expect_at(cyc + 1, K_INST, NOP);
      expect_at(cyc + 2, K_DONE, 32'd0);
      step();
      rst = 1'b0;
      step();
      fetch(32'h0);
      fetch(32'h4);

      // Randomized loads of varied length, each followed by random fetches.
      for (int r = 0; r < 5; r++) begin
         q = {};
         for (int i = 0; i < int'($urandom_range(4 * D + 5)); i++) q.push_back(8'($urandom));
         load(q, 1'($urandom_range(1)));
         random_fetches(15);
      end

      idle_inputs();
      for (int i = 0; i < 6; i++) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
